// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: turns a valid/ready command into one
// bus cycle and returns read data or a timeout error on a valid/ready response.
`timescale 1ns/1ps
module wb_host_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t           state_q, state_d;
    logic             run_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_d, stb_d, we_d, rsp_valid_d, rsp_err_d;
    logic [31:0]      adr_d, dat_d, rsp_dat_d;
    logic [3:0]       sel_d;

    // run_q keeps cmd_ready low while reset is held and for the release cycle
    assign cmd_ready = run_q && (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = wbm_cyc_o;
        stb_d       = wbm_stb_o;
        we_d        = wbm_we_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        sel_d       = wbm_sel_o;
        rsp_valid_d = rsp_valid;
        rsp_dat_d   = rsp_dat;
        rsp_err_d   = rsp_err;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // ack has priority over a timeout landing in the same cycle
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = wbm_we_o ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            cnt_q     <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            wbm_sel_o <= 4'h0;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            cnt_q     <= cnt_d;
            wbm_cyc_o <= cyc_d;
            wbm_stb_o <= stb_d;
            wbm_we_o  <= we_d;
            wbm_adr_o <= adr_d;
            wbm_dat_o <= dat_d;
            wbm_sel_o <= sel_d;
            rsp_valid <= rsp_valid_d;
            rsp_dat   <= rsp_dat_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: write, wait-state read, timeout, late ack,
// response backpressure and reset in the middle of a transfer.
`timescale 1ns/1ps
module tb_wb_host_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;

    int errors = 0;
    int checks = 0;
    int n;

    wb_host_master #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one command at a negedge; returns at the negedge of bus cycle 1
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        chk1("ready_before_accept", cmd_ready, 1'b1);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("rsp_valid_after_handshake", rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0;

        // reset values
        @(negedge clk);
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_cyc", wbm_cyc_o, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_adr", wbm_adr_o, 32'h0);
        chk32("rst_rsp_dat", rsp_dat, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("ready_after_release", cmd_ready, 1'b1);

        // zero-wait write
        issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        chk1("wr_cyc", wbm_cyc_o, 1'b1);
        chk1("wr_stb", wbm_stb_o, 1'b1);
        chk1("wr_we", wbm_we_o, 1'b1);
        chk32("wr_adr", wbm_adr_o, 32'h3000_0004);
        chk32("wr_dat", wbm_dat_o, 32'hA5A5_1234);
        chk32("wr_sel", {28'h0, wbm_sel_o}, 32'hF);
        chk1("wr_busy_ready", cmd_ready, 1'b0);
        wbm_dat_i = 32'hFFFF_FFFF;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk1("wr_cyc_drop", wbm_cyc_o, 1'b0);
        chk1("wr_rsp_valid", rsp_valid, 1'b1);
        chk1("wr_rsp_err", rsp_err, 1'b0);
        chk32("wr_rsp_dat", rsp_dat, 32'h0);
        consume();
        chk1("wr_idle_ready", cmd_ready, 1'b1);

        // read with 3 wait states
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        wbm_dat_i = 32'hDEAD_BEEF;
        n = 0;
        for (int i = 1; i <= 4; i++) begin
            if (wbm_cyc_o) n++;
            wbm_ack_i = (i == 4);
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        chk32("rd3_cyc_cycles", 32'(n), 32'd4);
        chk1("rd3_cyc_drop", wbm_cyc_o, 1'b0);
        chk1("rd3_rsp_valid", rsp_valid, 1'b1);
        chk32("rd3_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
        chk1("rd3_rsp_err", rsp_err, 1'b0);
        consume();

        // timeout: no ack
        issue(1'b0, 32'h3000_000C, 32'h0, 4'h3);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            if (wbm_cyc_o) n++;
            @(negedge clk);
        end
        chk32("to_cyc_cycles", 32'(n), 32'd8);
        chk1("to_rsp_valid", rsp_valid, 1'b1);
        chk1("to_rsp_err", rsp_err, 1'b1);
        chk32("to_rsp_dat", rsp_dat, 32'h0);
        wbm_dat_i = 32'h5555_AAAA;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk1("to_late_ack_err", rsp_err, 1'b1);
        chk32("to_late_ack_dat", rsp_dat, 32'h0);
        consume();
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk1("to_idle_ack_no_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        chk1("to_idle_ack_no_rsp2", rsp_valid, 1'b0);
        chk1("to_idle_ack_no_cyc", wbm_cyc_o, 1'b0);

        // ack in the final timeout cycle wins
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        wbm_dat_i = 32'h1111_2222;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            if (wbm_cyc_o) n++;
            wbm_ack_i = (i == 8);
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        chk32("last_cyc_cycles", 32'(n), 32'd8);
        chk1("last_rsp_valid", rsp_valid, 1'b1);
        chk1("last_rsp_err", rsp_err, 1'b0);
        chk32("last_rsp_dat", rsp_dat, 32'h1111_2222);
        consume();

        // response backpressure with cmd_valid held high
        cmd_we = 1'b1; cmd_adr = 32'h3000_0014; cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'hC;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk32("bp_a_adr", wbm_adr_o, 32'h3000_0014);
        cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0; cmd_sel = 4'hF;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk1("bp_cmd_ready", cmd_ready, 1'b0);
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chk1("bp_rsp_err", rsp_err, 1'b0);
            chk32("bp_rsp_dat", rsp_dat, 32'h0);
            chk1("bp_cyc", wbm_cyc_o, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("bp_ready_after_hs", cmd_ready, 1'b1);
        chk1("bp_no_cyc_yet", wbm_cyc_o, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk1("bp_b_cyc", wbm_cyc_o, 1'b1);
        chk32("bp_b_adr", wbm_adr_o, 32'h3000_0020);
        chk1("bp_b_we", wbm_we_o, 1'b0);
        wbm_dat_i = 32'hCAFE_0001;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk1("bp_b_rsp_valid", rsp_valid, 1'b1);
        chk32("bp_b_rsp_dat", rsp_dat, 32'hCAFE_0001);
        consume();

        // reset in the 2nd wait cycle
        issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rst_cyc", wbm_cyc_o, 1'b0);
        chk1("mid_rst_stb", wbm_stb_o, 1'b0);
        chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("mid_rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_ready", cmd_ready, 1'b1);
        chk1("post_rst_no_rsp", rsp_valid, 1'b0);
        issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        wbm_dat_i = 32'h1234_5678;
        @(negedge clk);
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk1("post_rst_rsp_valid", rsp_valid, 1'b1);
        chk1("post_rst_rsp_err", rsp_err, 1'b0);
        chk32("post_rst_rsp_dat", rsp_dat, 32'h1234_5678);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
